// File: rtl/speed_pkg.sv
// Shared types, widths and the period helper for the game-speed controller.
package speed_pkg;

  localparam int LEVEL_W = 3;
  localparam int CNT_W   = 32;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  // Tick period for a level: the base period halves per level, floored at min_period.
  function automatic logic [CNT_W-1:0] period_of(
    input logic [LEVEL_W-1:0] lvl,
    input logic [CNT_W-1:0]   base_period = 32'd50_000_000,
    input logic [CNT_W-1:0]   min_period  = 32'd2
  );
    logic [CNT_W-1:0] shifted;
    shifted = base_period >> lvl;
    return (shifted < min_period) ? min_period : shifted;
  endfunction

endpackage

// File: rtl/speed_controller_if.sv
// Control and status bundle between the game-logic layer (master) and the speed controller (slave).
interface speed_controller_if;
  import speed_pkg::*;

  logic               start;
  logic               stop;
  logic               pause;
  logic               level_up;
  logic               level_clr;
  logic               tick;
  logic [LEVEL_W-1:0] level;
  logic               running;
  logic               paused;

  modport master (
    output start, stop, pause, level_up, level_clr,
    input  tick, level, running, paused
  );

  modport slave (
    input  start, stop, pause, level_up, level_clr,
    output tick, level, running, paused
  );

endinterface

// File: rtl/speed_tick_counter.sv
// Free-running period counter: counts while enabled and flags the cycle it reaches period-1.
module speed_tick_counter
  import speed_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic [CNT_W-1:0] period,
  output logic             wrap
);

  logic [CNT_W-1:0] cnt;

  assign wrap = enable && (cnt == period - CNT_W'(1));

  // clear beats counting so a level change on a wrap cycle still restarts from zero
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= wrap ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/speed_controller.sv
// Game-speed controller: IDLE/RUN/PAUSE FSM that emits a one-cycle tick every period_of(level) cycles.
// Optional auto-ramp (level rises every RAMP_TICKS ticks) is enabled by defining SPEED_AUTO_RAMP_EN.
module speed_controller
  import speed_pkg::*;
#(
  parameter int BASE_PERIOD = 50_000_000,
  parameter int MIN_PERIOD  = 2,
  parameter int RAMP_TICKS  = 32
) (
  input  logic               clk,
  input  logic               reset,
  speed_controller_if.slave  bus
);

  state_t             state;
  state_t             state_next;
  logic [LEVEL_W-1:0] level_q;
  logic [LEVEL_W-1:0] level_next;
  logic               level_changed;
  logic               tick_q;
  logic               running_q;
  logic               paused_q;
  logic               cnt_enable;
  logic               cnt_clear;
  logic               wrap;
  logic               ramp_inc;
  logic [CNT_W-1:0]   period;

  assign period = period_of(level_q, CNT_W'(BASE_PERIOD), CNT_W'(MIN_PERIOD));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start && !bus.stop) state_next = RUN;
      RUN:     if (bus.stop) state_next = IDLE;
               else if (bus.pause) state_next = PAUSE;
      PAUSE:   if (bus.stop) state_next = IDLE;
               else if (!bus.pause) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    level_next = level_q;
    if (bus.level_clr) begin
      level_next = '0;
    end else if ((bus.level_up || ramp_inc) && (level_q != LEVEL_MAX)) begin
      level_next = level_q + LEVEL_W'(1);
    end
    level_changed = (level_next != level_q);
  end

  // counting only continues in a cycle that stays in RUN, so leaving RUN never produces a tick
  assign cnt_enable = (state == RUN) && !bus.stop && !bus.pause;
  assign cnt_clear  = (state == IDLE) || bus.stop || level_changed;

  speed_tick_counter u_counter (
    .clk    (clk),
    .reset  (reset),
    .enable (cnt_enable),
    .clear  (cnt_clear),
    .period (period),
    .wrap   (wrap)
  );

`ifdef SPEED_AUTO_RAMP_EN
  logic [CNT_W-1:0] ramp_cnt;

  assign ramp_inc = wrap && (ramp_cnt == CNT_W'(RAMP_TICKS - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      ramp_cnt <= '0;
    end else if (level_changed || ramp_inc) begin
      ramp_cnt <= '0;
    end else if (wrap) begin
      ramp_cnt <= ramp_cnt + CNT_W'(1);
    end
  end
`else
  localparam int unused_ramp_ticks = RAMP_TICKS;
  assign ramp_inc = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      level_q   <= '0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
      paused_q  <= 1'b0;
    end else begin
      state     <= state_next;
      level_q   <= level_next;
      tick_q    <= wrap;
      running_q <= (state_next == RUN);
      paused_q  <= (state_next == PAUSE);
    end
  end

  assign bus.tick    = tick_q;
  assign bus.level   = level_q;
  assign bus.running = running_q;
  assign bus.paused  = paused_q;

endmodule

// File: tb/tb_speed_controller.sv
// Directed bench for speed_controller with BASE_PERIOD=64, MIN_PERIOD=2, RAMP_TICKS=4.
module tb_speed_controller;
  import speed_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  speed_controller_if bus ();

  speed_controller #(
    .BASE_PERIOD (64),
    .MIN_PERIOD  (2),
    .RAMP_TICKS  (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Counts edges until tick is seen high just after an edge; returns limit on timeout.
  task automatic wait_tick(input int limit, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (bus.tick !== 1'b1 && n < limit);
  endtask

  task automatic do_reset();
    reset         = 1'b0;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.pause     = 1'b0;
    bus.level_up  = 1'b0;
    bus.level_clr = 1'b0;
    step(2);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    reset     = 1'b0;
    bus.start = 1'b1;
    step(2);
    total++; if (bus.tick !== 1'b0)    begin bad++; $display("FAIL reset_tick got=%b want=0", bus.tick); end
    total++; if (bus.level !== 3'd0)   begin bad++; $display("FAIL reset_level got=%0d want=0", bus.level); end
    total++; if (bus.running !== 1'b0) begin bad++; $display("FAIL reset_running got=%b want=0", bus.running); end
    total++; if (bus.paused !== 1'b0)  begin bad++; $display("FAIL reset_paused got=%b want=0", bus.paused); end
    bus.start = 1'b0;
    reset     = 1'b1;
    step(1);
    total++; if (bus.running !== 1'b0) begin bad++; $display("FAIL idle_running got=%b want=0", bus.running); end
  endtask

  task automatic test_basic_run();
    int n;
    do_reset();
    bus.start = 1'b1;
    wait_tick(80, n);
    total++; if (n !== 65) begin bad++; $display("FAIL first_tick got=%0d want=65", n); end
    total++; if (bus.running !== 1'b1) begin bad++; $display("FAIL run_running got=%b want=1", bus.running); end
    total++; if (bus.level !== 3'd0)   begin bad++; $display("FAIL run_level got=%0d want=0", bus.level); end
    for (int i = 0; i < 2; i++) begin
      wait_tick(80, n);
      total++; if (n !== 64) begin bad++; $display("FAIL repeat_tick%0d got=%0d want=64", i, n); end
    end
    step(1);
    total++; if (bus.tick !== 1'b0) begin bad++; $display("FAIL tick_width got=%b want=0", bus.tick); end
    bus.start = 1'b0;
    bus.stop  = 1'b1;
    step(1);
    bus.stop = 1'b0;
    total++; if (bus.running !== 1'b0) begin bad++; $display("FAIL stop_running got=%b want=0", bus.running); end
  endtask

  task automatic test_level();
    int n;
    do_reset();
    bus.level_up = 1'b1;
    step(3);
    bus.level_up = 1'b0;
    total++; if (bus.level !== 3'd3) begin bad++; $display("FAIL level3 got=%0d want=3", bus.level); end
    bus.start = 1'b1;
    wait_tick(20, n);
    total++; if (n !== 9) begin bad++; $display("FAIL lvl3_first got=%0d want=9", n); end
    wait_tick(20, n);
    total++; if (n !== 8) begin bad++; $display("FAIL lvl3_period got=%0d want=8", n); end
    // level change right after a tick restarts the count with the new period of 4
    bus.level_up = 1'b1;
    step(1);
    bus.level_up = 1'b0;
    total++; if (bus.level !== 3'd4) begin bad++; $display("FAIL level4 got=%0d want=4", bus.level); end
    wait_tick(20, n);
    total++; if (n !== 4) begin bad++; $display("FAIL lvl4_after_change got=%0d want=4", n); end
    bus.level_up = 1'b1;
    step(3);
    bus.level_up = 1'b0;
    total++; if (bus.level !== 3'd7) begin bad++; $display("FAIL level7 got=%0d want=7", bus.level); end
    wait_tick(20, n);
    total++; if (n !== 2) begin bad++; $display("FAIL lvl7_first got=%0d want=2", n); end
    wait_tick(20, n);
    total++; if (n !== 2) begin bad++; $display("FAIL lvl7_period got=%0d want=2", n); end
    // saturated request must not restart the count: counter reaches 1 regardless
    bus.level_up = 1'b1;
    step(1);
    bus.level_up = 1'b0;
    total++; if (bus.level !== 3'd7) begin bad++; $display("FAIL level_sat got=%0d want=7", bus.level); end
    wait_tick(20, n);
    total++; if (n !== 1) begin bad++; $display("FAIL sat_keeps_cnt got=%0d want=1", n); end
  endtask

  task automatic test_pause();
    int n;
    int seen;
    do_reset();
    bus.start = 1'b1;
    wait_tick(80, n);
    total++; if (n !== 65) begin bad++; $display("FAIL pause_first got=%0d want=65", n); end
    step(20);
    bus.pause = 1'b1;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (bus.tick === 1'b1) seen++;
    end
    total++; if (seen !== 0)          begin bad++; $display("FAIL paused_ticks got=%0d want=0", seen); end
    total++; if (bus.paused !== 1'b1)  begin bad++; $display("FAIL paused_flag got=%b want=1", bus.paused); end
    total++; if (bus.running !== 1'b0) begin bad++; $display("FAIL paused_running got=%b want=0", bus.running); end
    // resume edge plus 44 counts from the held value of 20 up to the wrap
    bus.pause = 1'b0;
    wait_tick(80, n);
    total++; if (n !== 45) begin bad++; $display("FAIL resume_tick got=%0d want=45", n); end
    total++; if (bus.running !== 1'b1) begin bad++; $display("FAIL resume_running got=%b want=1", bus.running); end
    total++; if (bus.paused !== 1'b0)  begin bad++; $display("FAIL resume_paused got=%b want=0", bus.paused); end
  endtask

  task automatic test_priority();
    int n;
    do_reset();
    bus.start = 1'b1;
    wait_tick(80, n);
    step(10);
    bus.stop  = 1'b1;
    bus.pause = 1'b1;
    step(1);
    total++; if (bus.running !== 1'b0) begin bad++; $display("FAIL prio_running got=%b want=0", bus.running); end
    total++; if (bus.paused !== 1'b0)  begin bad++; $display("FAIL prio_paused got=%b want=0", bus.paused); end
    step(3);
    total++; if (bus.running !== 1'b0) begin bad++; $display("FAIL stop_over_start got=%b want=0", bus.running); end
    bus.stop  = 1'b0;
    bus.pause = 1'b0;
    wait_tick(80, n);
    total++; if (n !== 65) begin bad++; $display("FAIL restart_tick got=%0d want=65", n); end
    bus.start = 1'b0;
    bus.stop  = 1'b1;
    bus.level_up = 1'b1;
    step(2);
    bus.stop = 1'b0;
    total++; if (bus.level !== 3'd2) begin bad++; $display("FAIL prio_level2 got=%0d want=2", bus.level); end
    bus.level_clr = 1'b1;
    step(1);
    bus.level_clr = 1'b0;
    bus.level_up  = 1'b0;
    total++; if (bus.level !== 3'd0) begin bad++; $display("FAIL clr_over_up got=%0d want=0", bus.level); end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    bus.start = 1'b1;
    wait_tick(80, n);
    step(63);
    reset = 1'b0;
    step(1);
    total++; if (bus.tick !== 1'b0)    begin bad++; $display("FAIL mid_tick got=%b want=0", bus.tick); end
    total++; if (bus.running !== 1'b0) begin bad++; $display("FAIL mid_running got=%b want=0", bus.running); end
    total++; if (bus.paused !== 1'b0)  begin bad++; $display("FAIL mid_paused got=%b want=0", bus.paused); end
    total++; if (bus.level !== 3'd0)   begin bad++; $display("FAIL mid_level got=%0d want=0", bus.level); end
    reset     = 1'b1;
    bus.start = 1'b0;
    step(1);
    total++; if (bus.tick !== 1'b0) begin bad++; $display("FAIL mid_dropped got=%b want=0", bus.tick); end
  endtask

`ifdef SPEED_AUTO_RAMP_EN
  task automatic test_ramp();
    int n;
    do_reset();
    bus.start = 1'b1;
    wait_tick(80, n);
    total++; if (n !== 65) begin bad++; $display("FAIL ramp_first got=%0d want=65", n); end
    wait_tick(80, n);
    wait_tick(80, n);
    total++; if (bus.level !== 3'd0) begin bad++; $display("FAIL ramp_early got=%0d want=0", bus.level); end
    wait_tick(80, n);
    total++; if (bus.level !== 3'd1) begin bad++; $display("FAIL ramp_level1 got=%0d want=1", bus.level); end
    for (int i = 0; i < 4; i++) begin
      wait_tick(80, n);
      total++; if (n !== 32) begin bad++; $display("FAIL ramp_p32_%0d got=%0d want=32", i, n); end
    end
    total++; if (bus.level !== 3'd2) begin bad++; $display("FAIL ramp_level2 got=%0d want=2", bus.level); end
    wait_tick(80, n);
    total++; if (n !== 16) begin bad++; $display("FAIL ramp_p16 got=%0d want=16", n); end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    do_reset();
    test_reset();
    test_basic_run();
    test_level();
    test_pause();
    test_priority();
    test_reset_mid();
`ifdef SPEED_AUTO_RAMP_EN
    test_ramp();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
